// File: rtl/alu_op_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_op_arbiter
// Description : Shares one registered 4-bit ALU between two requesters. It
//               accepts one op at a time, pulses a single one-hot ALU control
//               and returns the captured result through a held response.
//               Optional macro ALU_ARB_RR_EN selects round-robin arbitration.
//               Without it, arbitration is fixed priority with req0 first.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_arbiter #(
    parameter int DATA_W  = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovf,
    output logic              alu_add,
    output logic              alu_sub,
    output logic              alu_lshift,
    output logic              alu_rshift,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow,
    output logic              busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_LSH = 2'b10;
    localparam logic [1:0] c_OP_RSH = 2'b11;

    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    logic [1:0]        r_state;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_id;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_ovf;

    logic              w_win;
    logic              w_accept;

`ifdef ALU_ARB_RR_EN
    // r_prio names the requester that wins a tie; it flips away from each winner.
    logic r_prio;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_prio <= ~w_win;
        end
    end

    assign w_win = (req0_valid && req1_valid) ? r_prio : req1_valid;
`else
    assign w_win = ~req0_valid & req1_valid;
`endif

    // Readies are gated by reset so every output reads 0 while reset is held.
    assign w_accept   = reset && (r_state == c_ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = w_accept & ~w_win;
    assign req1_ready = w_accept &  w_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_op       <= 2'b00;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_cnt      <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_ovf  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_win ? req1_op : req0_op;
                        r_a     <= w_win ? req1_a  : req0_a;
                        r_b     <= w_win ? req1_b  : req0_b;
                        r_id    <= w_win;
                        r_state <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_cnt   <= CNT_W'(ALU_LAT);
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_rsp_data <= alu_out;
                        r_rsp_ovf  <= alu_overflow;
                        r_rsp_id   <= r_id;
                        r_state    <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign alu_add    = (r_state == c_ST_ISSUE) && (r_op == c_OP_ADD);
    assign alu_sub    = (r_state == c_ST_ISSUE) && (r_op == c_OP_SUB);
    assign alu_lshift = (r_state == c_ST_ISSUE) && (r_op == c_OP_LSH);
    assign alu_rshift = (r_state == c_ST_ISSUE) && (r_op == c_OP_RSH);
    assign alu_in1    = r_a;
    assign alu_in2    = r_b;

    assign rsp_valid  = (r_state == c_ST_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_ovf    = r_rsp_ovf;
    assign busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_op_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_arbiter
// Description : Scoreboard bench for alu_op_arbiter with a registered ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_arbiter;

    localparam int DATA_W  = 4;
    localparam int ALU_LAT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]        req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_ovf;
    logic [DATA_W-1:0] rsp_data;
    logic              alu_add, alu_sub, alu_lshift, alu_rshift;
    logic [DATA_W-1:0] alu_in1, alu_in2, alu_out;
    logic              alu_overflow, busy;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] data;
        logic              ovf;
    } rsp_t;

    rsp_t sb[$];
    rsp_t r_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_arbiter #(.DATA_W(DATA_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
        .alu_add(alu_add), .alu_sub(alu_sub), .alu_lshift(alu_lshift), .alu_rshift(alu_rshift),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .alu_overflow(alu_overflow),
        .busy(busy)
    );

    // Expected ALU result {carry/borrow/shifted-out bit, data}.
    function automatic logic [4:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {a[3], a[2:0], 1'b0};
            default: return {a[0], 1'b0, a[3:1]};
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_out      <= '0;
            alu_overflow <= 1'b0;
        end else if (alu_add || alu_sub || alu_lshift || alu_rshift) begin
            {alu_overflow, alu_out} <= alu_ref({alu_lshift | alu_rshift, alu_sub | alu_rshift}, alu_in1, alu_in2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ctrl_onehot", 32'($countones({alu_add, alu_sub, alu_lshift, alu_rshift}) <= 1), 1);
        if (reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                r_exp = sb.pop_front();
                chk("rsp_id",   32'(rsp_id),   32'(r_exp.id));
                chk("rsp_data", 32'(rsp_data), 32'(r_exp.data));
                chk("rsp_ovf",  32'(rsp_ovf),  32'(r_exp.ovf));
            end
        end
    end

    function automatic logic [3:0] ctrl_vec();
        return {alu_add, alu_sub, alu_lshift, alu_rshift};
    endfunction

    // Present one op from an idle DUT at cycle T, check the T and T+1 behaviour.
    task automatic issue_op(input bit id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [4:0] exp, input bit expect_rsp);
        logic [3:0] onehot;
        onehot = 4'b1000 >> op;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        chk("ready_winner", 32'(id ? req1_ready : req0_ready), 1);
        chk("ready_other",  32'(id ? req0_ready : req1_ready), 0);
        if (expect_rsp) sb.push_back('{id: id, data: exp[3:0], ovf: exp[4]});
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("ctrl_issue", 32'(ctrl_vec()), 32'(onehot));
        chk("alu_in1", 32'(alu_in1), 32'(a));
        if (!op[1]) chk("alu_in2", 32'(alu_in2), 32'(b));
        chk("ready_busy", 32'(req0_ready | req1_ready), 0);
    endtask

    // Finish from T+1: WAIT cycles quiet, response at T+3, consumed, back to IDLE.
    task automatic finish_op();
        for (int i = 0; i < ALU_LAT; i++) begin
            @(posedge clk); #1;
            chk("ctrl_wait", 32'(ctrl_vec()), 0);
            chk("rsp_early", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        chk("rsp_valid_lat", 32'(rsp_valid), 1);
        @(posedge clk); #1;
        chk("idle_after_rsp", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_ids;
        logic [4:0] e;
        int         acc;
        bit         w;
`ifdef ALU_ARB_RR_EN
        exp_ids = 4'b1010;
`else
        exp_ids = 4'b0000;
`endif
        reset = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'b00; req1_op = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #12;
        chk("rst_readies", 32'(req0_ready | req1_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_ovf}), 0);
        chk("rst_alu", 32'({ctrl_vec(), alu_in1, alu_in2}), 0);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("rel_both_r0", 32'(req0_ready), 1);
        chk("rel_both_r1", 32'(req1_ready), 0);
        req0_valid = 1'b0; #1;
        chk("rel_only_r1", 32'(req1_ready), 1);
        req1_valid = 1'b0; #1;
        chk("rel_none", 32'(req0_ready | req1_ready), 0);
        @(posedge clk); #1;

        issue_op(1'b0, 2'b00, 4'd7, 4'd5, 5'b0_1100, 1'b1); finish_op();
        issue_op(1'b1, 2'b00, 4'd9, 4'd8, 5'b1_0001, 1'b1); finish_op();
        issue_op(1'b0, 2'b01, 4'd3, 4'd5, 5'b1_1110, 1'b1); finish_op();
        issue_op(1'b0, 2'b10, 4'b1001, 4'hF, 5'b1_0010, 1'b1); finish_op();
        issue_op(1'b1, 2'b11, 4'b0110, 4'h0, 5'b0_0011, 1'b1); finish_op();

        // Reset during WAIT discards the op.
        issue_op(1'b0, 2'b00, 4'd1, 4'd1, 5'd2, 1'b0);
        @(posedge clk); #1;
        chk("wait_reached", 32'(busy), 1);
        req0_valid = 1'b1;
        reset = 1'b0; #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rsp", 32'({rsp_valid, rsp_data, rsp_ovf, rsp_id}), 0);
        chk("midrst_ready", 32'(req0_ready | req1_ready), 0);
        chk("midrst_alu", 32'({ctrl_vec(), alu_in1}), 0);
        @(posedge clk); @(negedge clk); reset = 1'b1; #1;
        chk("midrst_rel_ready", 32'(req0_ready), 1);
        req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 32'(rsp_valid | busy), 0);
        end

        // Both requesters contend for four accepts.
        acc = 0;
        for (int cyc = 0; cyc < 60 && acc < 4; cyc++) begin
            req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'(acc); req0_b = 4'd2;
            req1_valid = 1'b1; req1_op = 2'b11; req1_a = 4'(4'hA + acc); req1_b = 4'd0;
            #1;
            chk("arb_ready_onehot", 32'(req0_ready & req1_ready), 0);
            if (req0_ready || req1_ready) begin
                w = req1_ready;
                chk("arb_id", 32'(w), 32'(exp_ids[acc]));
                e = w ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
                sb.push_back('{id: w, data: e[3:0], ovf: e[4]});
                acc++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("arb_accepts", acc, 4);
        for (int i = 0; i < 20 && (sb.size() != 0 || busy); i++) begin
            @(posedge clk); #1;
        end
        chk("arb_drained", sb.size(), 0);

        // Consumer stalls for five cycles with both requesters waiting.
        rsp_ready = 1'b0;
        issue_op(1'b0, 2'b01, 4'd3, 4'd5, 5'b1_1110, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stall_rsp_valid", 32'(rsp_valid), 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_hold", 32'({rsp_valid, rsp_id, rsp_data, rsp_ovf}), 32'({1'b1, 1'b0, 4'hE, 1'b1}));
            chk("stall_readies", 32'(req0_ready | req1_ready), 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", 32'(busy | rsp_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        chk("final_idle", 32'(busy), 0);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
